// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder slice.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_t;

   localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder; the serial adder reuses this one cell
// for every bit position, feeding its carry back through a flip-flop.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands load in parallel on start, then one bit
// per clock passes LSB-first through a single full adder with a registered
// carry. The finished sum and carry-out are published on the completing edge
// and held until the next result is ready.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sa_state_t        state;
   sa_state_t        next_state;
   logic             load;
   logic             last_bit;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the WIDTH-1 sum bits produced so far; the bit being produced this
   // cycle is prepended to form the full-width partial sum in s_next.
   logic [WIDTH-2:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .c    (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign s_next   = {fa_sum, s_sr};
   assign last_bit = (cnt == LAST);
   assign busy     = (state == SHIFT);
   assign done     = (state == DONE);

   // Next-state decode; load fires when a start is accepted in IDLE or DONE.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load       = 1'b1;
               next_state = SHIFT;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath: load operands, shift one bit per SHIFT cycle, publish on the last bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr    <= '0;
         b_sr    <= '0;
         s_sr    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
      end else if (load) begin
         a_sr  <= a_in;
         b_sr  <= b_in;
         carry <= cin;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         s_sr  <= s_next[WIDTH-1:1];
         carry <= fa_cout;
         if (last_bit) begin
            sum_out <= s_next;
            cout    <= fa_cout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
